sram_fifo_ctrl_128x36: RTL

- Ready/valid FIFO controller that drives one 128x36 single-port synchronous SRAM macro: one access per cycle, read data valid the cycle after issue.
- Owns the write and read pointers, arbitrates the single port between enqueue writes and prefetch reads, and hides read latency with a 2-entry output staging buffer.
- Includes an empty-FIFO bypass, so the consumer sees a plain decoupled queue of 130 entries.

---
 rtl/sram_fifo_ctrl_128x36_pkg.sv | 16 +
 rtl/sram_fifo_stage2.sv | 50 +++++
 rtl/sram_fifo_ctrl_128x36.sv | 111 +++++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_128x36_pkg.sv
// Shared constants and payload bundle for the 128x36 SRAM FIFO controller and
// sibling macro wrappers.
package sram_fifo_ctrl_128x36_pkg;

   localparam int unsigned WIDTH  = 36;
   localparam int unsigned DEPTH  = 128;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned STAGE  = 2;
   localparam int unsigned CNT_W  = 8;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] bits;
   } fifo_beat_t;

endpackage

// File: rtl/sram_fifo_stage2.sv
// Two-entry output staging buffer: head feeds the consumer, tail absorbs one
// extra word so an SRAM read can be in flight while the head is held.
module sram_fifo_stage2
   import sram_fifo_ctrl_128x36_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_cnt
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_cnt;

   logic w_full;
   assign w_full = (r_cnt == 2'(STAGE));

   // Pop shifts tail to head; a same-cycle push lands in the freed slot.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
         if (i_pop && w_full)
            r_head <= r_tail;
         else if (i_push && ((r_cnt == 2'd0) || (i_pop && r_cnt == 2'd1)))
            r_head <= i_push_data;
         if (i_push && ((r_cnt == 2'd1 && !i_pop) || (w_full && i_pop)))
            r_tail <= i_push_data;
      end
   end

   assign o_valid = (r_cnt != 2'd0);
   assign o_head  = r_head;
   assign o_cnt   = r_cnt;

   a_stage_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_push && !i_pop && w_full));

   a_stage_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_pop && r_cnt == 2'd0));

endmodule

// File: rtl/sram_fifo_ctrl_128x36.sv
// Ready/valid FIFO over a 128x36 single-port SRAM: pointer/arbitration logic,
// empty-queue bypass and a 2-entry staging buffer hiding the 1-cycle read.
module sram_fifo_ctrl_128x36
   import sram_fifo_ctrl_128x36_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [WIDTH-1:0]  enq_bits,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [WIDTH-1:0]  deq_bits,
   output logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [WIDTH-1:0]  sram_wdata,
   input  logic [WIDTH-1:0]  sram_rdata
);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_sram_cnt;
   logic [CNT_W-1:0]  r_count;
   logic              r_inflight;
   logic              r_prio_rd;

   logic       w_deq_fire;
   logic       w_enq_fire;
   logic [1:0] w_stage_cnt;
   logic [2:0] w_occ;
   logic       w_room;
   logic       w_sram_empty;
   logic       w_sram_full;
   logic       w_bypass_ok;
   logic       w_want_rd;
   logic       w_want_wr;
   logic       w_grant_rd;
   logic       w_wr_issue;
   fifo_beat_t w_push;

   assign w_deq_fire   = deq_valid & deq_ready;
   assign w_occ        = 3'(w_stage_cnt) + 3'(r_inflight) - 3'(w_deq_fire);
   assign w_room       = (w_occ < 3'd2);
   assign w_sram_empty = (r_sram_cnt == '0);
   assign w_sram_full  = (r_sram_cnt == CNT_W'(DEPTH));

   assign w_bypass_ok = w_sram_empty & ~r_inflight & w_room;
   assign w_want_rd   = ~w_sram_empty & w_room;
   assign w_want_wr   = enq_valid & ~w_sram_full & ~w_bypass_ok;

   // Reads yield only to a write that can actually issue, so a producer
   // stalled on a full SRAM never blocks the drain path.
   assign w_grant_rd = w_want_rd & (r_prio_rd | ~w_want_wr);
   assign enq_ready  = w_bypass_ok | (~w_sram_full & ~(w_want_rd & r_prio_rd));
   assign w_enq_fire = enq_valid & enq_ready;
   assign w_wr_issue = w_enq_fire & ~w_bypass_ok;

   // Capture and bypass are exclusive: bypass requires no read in flight.
   assign w_push.valid = r_inflight | (w_enq_fire & w_bypass_ok);
   assign w_push.bits  = r_inflight ? sram_rdata : enq_bits;

   always_comb begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (w_grant_rd) begin
         sram_en   = 1'b1;
         sram_addr = r_rd_ptr;
      end else if (w_wr_issue) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = r_wr_ptr;
         sram_wdata = enq_bits;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_sram_cnt <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
         r_prio_rd  <= 1'b0;
      end else begin
         if (w_grant_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (w_wr_issue) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         r_sram_cnt <= r_sram_cnt + CNT_W'(w_wr_issue) - CNT_W'(w_grant_rd);
         r_count    <= r_count + CNT_W'(w_enq_fire) - CNT_W'(w_deq_fire);
         r_inflight <= w_grant_rd;
         if (w_want_rd && w_want_wr) r_prio_rd <= ~r_prio_rd;
      end
   end

   assign count = r_count;

   sram_fifo_stage2 u_stage (
      .i_clk       (clock),
      .i_rst_n     (reset),
      .i_push      (w_push.valid),
      .i_push_data (w_push.bits),
      .i_pop       (w_deq_fire),
      .o_valid     (deq_valid),
      .o_head      (deq_bits),
      .o_cnt       (w_stage_cnt)
   );

endmodule
